// File: rtl/t04_ack_pkg.sv
// rtl/t04_ack_pkg.sv - shared types and default parameters for the ack router
package t04_ack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } ack_state_t;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } ack_owner_t;

  localparam int         DEF_NUM_TGT  = 3;
  localparam int         DEF_TIMEOUT  = 255;
  localparam int         DEF_CNT_W    = 8;
  // Up to 8 targets; bit t set means target t reports a level busy.
  localparam logic [7:0] DEF_LVL_MASK = 8'h01;

endpackage

// File: rtl/t04_ack_timeout_cnt.sv
// rtl/t04_ack_timeout_cnt.sv - WAIT-cycle counter flagging a stuck target
module t04_ack_timeout_cnt
  import t04_ack_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over count so every WAIT phase starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Hit on the TIMEOUT-th WAIT cycle, i.e. when this cycle's increment would reach TIMEOUT.
  assign hit_o = en_i & (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/t04_ack_router.sv
// rtl/t04_ack_router.sv - two-port arbiter and completion tracker; T04_ACK_TIMEOUT_EN adds a WAIT timeout
module t04_ack_router
  import t04_ack_pkg::*;
#(
  parameter int         NUM_TGT      = DEF_NUM_TGT,
  parameter logic [7:0] TGT_LVL_MASK = DEF_LVL_MASK,
  parameter int         I_TGT        = 0,
  parameter int         TIMEOUT      = DEF_TIMEOUT,
  parameter int         CNT_W        = DEF_CNT_W,
  localparam int        SEL_W        = $clog2(NUM_TGT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_rd,
  input  logic               d_wr,
  input  logic [SEL_W-1:0]   d_sel,
  input  logic               i_req,
  input  logic [NUM_TGT-1:0] tgt_stat,
  output logic [NUM_TGT-1:0] tgt_go,
  output logic               d_ack,
  output logic               i_ack,
  output logic               err,
  output logic               busy_o
);

  ack_state_t         state_q, state_d;
  ack_owner_t         owner_q, owner_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_TGT-1:0] go_q, go_d;
  logic               d_ack_q, d_ack_d;
  logic               i_ack_q, i_ack_d;
  logic               err_q, err_d;

  logic d_req;
  logic sel_bad;
  logic bad_req;
  logic stat_sel;
  logic lvl_sel;
  logic done;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_hit;

  assign d_req   = d_rd | d_wr;
  assign sel_bad = {1'b0, d_sel} >= (SEL_W + 1)'(NUM_TGT);
  assign bad_req = d_req & (sel_bad | (d_rd & d_wr));

  // Pick the selected target's status bit and completion mode; other targets are ignored.
  always_comb begin
    stat_sel = 1'b0;
    lvl_sel  = 1'b0;
    for (int t = 0; t < NUM_TGT; t++) begin
      if (sel_q == SEL_W'(t)) begin
        stat_sel = tgt_stat[t];
        lvl_sel  = TGT_LVL_MASK[t];
      end
    end
  end

  // Level targets finish when busy drops, pulse targets when their ack bit is high.
  assign done = lvl_sel ? ~stat_sel : stat_sel;

  assign tmo_clr = (state_q == ISSUE);
  assign tmo_en  = (state_q == WAIT);

`ifdef T04_ACK_TIMEOUT_EN
  t04_ack_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .hit_o (tmo_hit)
  );
`else
  logic [CNT_W-1:0] unused_tmo;
  logic [1:0]       unused_tmo_ctl;
  assign unused_tmo     = CNT_W'(TIMEOUT);
  assign unused_tmo_ctl = {tmo_clr, tmo_en};
  assign tmo_hit        = 1'b0;
`endif

  // State, owner and latched target select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_D;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
    end
  end

  // Next state: data beats fetch in IDLE; bad data requests skip straight to ACK.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          owner_d = OWN_D;
          sel_d   = d_sel;
          state_d = bad_req ? ACK : ISSUE;
        end else if (i_req) begin
          owner_d = OWN_I;
          sel_d   = SEL_W'(I_TGT);
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (done || tmo_hit) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values, computed from the transition so the registered outputs line up with the state.
  always_comb begin
    go_d    = '0;
    d_ack_d = 1'b0;
    i_ack_d = 1'b0;
    err_d   = 1'b0;
    if (state_d == ISSUE) begin
      for (int t = 0; t < NUM_TGT; t++) begin
        go_d[t] = (sel_d == SEL_W'(t));
      end
    end
    if (state_d == ACK) begin
      d_ack_d = (owner_d == OWN_D);
      i_ack_d = (owner_d == OWN_I);
      // Entering ACK from IDLE means a bad request; from WAIT without done means timeout.
      err_d   = (state_q == IDLE) | ((state_q == WAIT) & ~done);
    end
  end

  // Registered strobes so nothing reaches the outputs combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_q    <= '0;
      d_ack_q <= 1'b0;
      i_ack_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      go_q    <= go_d;
      d_ack_q <= d_ack_d;
      i_ack_q <= i_ack_d;
      err_q   <= err_d;
    end
  end

  assign tgt_go = go_q;
  assign d_ack  = d_ack_q;
  assign i_ack  = i_ack_q;
  assign err    = err_q;
  assign busy_o = (state_q != IDLE);

endmodule
